fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Synchronous FIFO controller that owns the write and read sides of the FIFO storage. It accepts push/pop requests and generates write-enable, write address and read address for an internal dual-port RAM. It reports occupancy, full and empty, and presents the head entry on its output with first-word fall-through. It is the block that drives `ram_dual` in the Bootstrap FIFO unit.

## Interface
- `ADDRESS_WIDTH`, default 6, sets the RAM address width; depth is DEPTH = 2**ADDRESS_WIDTH.
- `DATA_WIDTH`, default 32, sets the entry width.
- `fifo_clk_i`, input, 1 bit: the single clock; all state changes on its rising edge.
- `fifo_rst_n_i`, input, 1 bit: asynchronous, active-low reset.
- `fifo_push_i`, input, 1 bit: write request.
- `fifo_writedata_i`, input, DATA_WIDTH bits: data to push.
- `fifo_pop_i`, input, 1 bit: read request, which consumes the head entry.
- `fifo_readdata_o`, output, DATA_WIDTH bits: head entry, combinational from RAM.
- `fifo_empty_o`, output, 1 bit: FIFO holds 0 entries.
- `fifo_full_o`, output, 1 bit: FIFO holds DEPTH entries.
- `fifo_count_o`, output, ADDRESS_WIDTH+1 bits: occupancy, 0..DEPTH.
- `fifo_err_clr_i`, input, 1 bit: clears the sticky error flags.
- `fifo_overflow_o`, output, 1 bit: sticky; a push was rejected.
- `fifo_underflow_o`, output, 1 bit: sticky; a pop was rejected.

## Operation
- Write pointer and read pointer are each ADDRESS_WIDTH+1 bits.
  - The low ADDRESS_WIDTH bits address the RAM.
  - The MSB is the wrap bit.
- Empty when the two pointers are equal.
- Full when the low bits are equal and the MSBs differ.
- Count = wr_ptr - rd_ptr, modulo 2**(ADDRESS_WIDTH+1).
- Accepted push (`push_ok`):
  - Condition: `fifo_push_i` and (not full, or pop_ok in the same cycle).
  - Drives RAM write-enable with address wr_ptr[AW-1:0].
  - wr_ptr increments by 1.
- Accepted pop (`pop_ok`):
  - Condition: `fifo_pop_i` and not empty.
  - rd_ptr increments by 1.
- Simultaneous push and pop:
  - Not full and not empty: both accepted; count unchanged.
  - When full: both accepted. The head is read combinationally before the edge, and the write lands at the freed slot.
  - When empty: only the push is accepted, with no bypass; underflow is set.
- Rejected requests:
  - A push rejected while full sets overflow.
  - A pop rejected while empty sets underflow.
  - Pointers and RAM are unchanged.
- `fifo_readdata_o` equals the RAM content at rd_ptr[AW-1:0]. It is valid whenever not empty and undefined while empty.
- Pointers wrap naturally at 2**(ADDRESS_WIDTH+1); there is no special case at the wrap.
- `fifo_err_clr_i` clears both error flags. If a new error event occurs in the same cycle, set has priority over clear.

## Timing
- Reset (asynchronous assertion, synchronous release with the clock):
  - wr_ptr = rd_ptr = 0.
  - `fifo_empty_o` = 1, `fifo_full_o` = 0, `fifo_count_o` = 0.
  - Overflow = 0, underflow = 0.
  - RAM contents are not cleared.
- Reset mid-operation discards all entries immediately.
- Flags and count are registered-state derived: they update on the edge after the accepted request.
- Push to pop latency: an entry pushed at edge N is visible on `fifo_readdata_o` after edge N, so it can be popped at edge N+1.
- Read data changes combinationally with rd_ptr; there is no read pipeline stage.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined: the overflow/underflow sticky registers and the clear logic are built.
- Macro not defined:
  - `fifo_overflow_o` and `fifo_underflow_o` are tied to 0.
  - `fifo_err_clr_i` is ignored.
  - The port list is unchanged.

## Structure
- Shared package `fifo_pkg` holds:
  - the default ADDRESS_WIDTH/DATA_WIDTH constants;
  - a pointer-width constant function (AW+1).
- One sub-module: `ram_dual`, instantiated as storage.
  - Write side: write-enable = push_ok, write address = wr_ptr[AW-1:0], write data = `fifo_writedata_i`.
  - Read address = rd_ptr[AW-1:0].
  - All pointer and flag logic lives in `fifo_ctrl`.

## Test plan
- Reset → empty = 1, full = 0, count = 0, overflow = underflow = 0.
- Fill and drain (AW = 2):
  - Push 0xA0..0xA3 → full = 1, count = 4.
  - Pop 4 times → data out 0xA0..0xA3 in order, then empty = 1.
- Overflow: push 0xFF while full with no pop → count stays 4, overflow = 1, 0xFF is never read. `fifo_err_clr_i` pulse → overflow = 0.
- Push and pop in the same cycle:
  - While full → count stays 4; the new word is read out after the old 3.
  - While empty → count = 1, underflow = 1.
- Wrap: 3 × (push 2, pop 2) with AW = 2 → pointers cross the wrap; data order preserved, flags correct.
- Reset asserted mid-stream with count = 3 → empty = 1 and count = 0 asynchronously. The next push/pop returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
package fifo_pkg;

  localparam int unsigned FIFO_ADDRESS_WIDTH = 6;
  localparam int unsigned FIFO_DATA_WIDTH    = 32;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ctrl_ram_dual.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on contents.
module ram_dual
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = FIFO_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = FIFO_DATA_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [ADDRESS_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_c_o
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: one entry per accepted push.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is combinational so the head entry falls through.
  assign rdata_c_o = mem_q[raddr_i];

endmodule : ram_dual

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller with first-word fall-through over ram_dual.
// Optional build macro FIFO_ERR_FLAGS_EN: builds the sticky overflow/underflow
// flags and their clear; otherwise both flags read 0 and the clear is ignored.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = FIFO_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = FIFO_DATA_WIDTH
) (
  input  logic                     fifo_clk_i,
  input  logic                     fifo_rst_n_i,
  input  logic                     fifo_push_i,
  input  logic [DATA_WIDTH-1:0]    fifo_writedata_i,
  input  logic                     fifo_pop_i,
  output logic [DATA_WIDTH-1:0]    fifo_readdata_o,
  output logic                     fifo_empty_o,
  output logic                     fifo_full_o,
  output logic [ADDRESS_WIDTH:0]   fifo_count_o,
  input  logic                     fifo_err_clr_i,
  output logic                     fifo_overflow_o,
  output logic                     fifo_underflow_o
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned PW = ptr_width(ADDRESS_WIDTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty_c, full_c;
  logic          push_ok_c, pop_ok_c;
  logic          push_rej_c, pop_rej_c;

  // Occupancy flags from the registered pointers.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Request acceptance; a pop while full frees the slot the push reuses.
  assign pop_ok_c   = fifo_pop_i && !empty_c;
  assign push_ok_c  = fifo_push_i && (!full_c || pop_ok_c);
  assign push_rej_c = fifo_push_i && !push_ok_c;
  assign pop_rej_c  = fifo_pop_i && !pop_ok_c;

  // Pointer next-state: each advances by one on its accepted request.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers; reset discards all entries at once.
  always_ff @(posedge fifo_clk_i or negedge fifo_rst_n_i) begin
    if (!fifo_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error next-state: a new event wins over a clear in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (fifo_err_clr_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push_rej_c) begin
      overflow_d = 1'b1;
    end
    if (pop_rej_c) begin
      underflow_d = 1'b1;
    end
  end

  // Sticky error registers.
  always_ff @(posedge fifo_clk_i or negedge fifo_rst_n_i) begin
    if (!fifo_rst_n_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_overflow_o  = overflow_q;
  assign fifo_underflow_o = underflow_q;
`else
  logic unused_err_c;

  // Error reporting not built: flags read 0 and the clear has no effect.
  assign unused_err_c     = fifo_err_clr_i ^ push_rej_c ^ pop_rej_c;
  assign fifo_overflow_o  = 1'b0;
  assign fifo_underflow_o = 1'b0;
`endif

  assign fifo_empty_o = empty_c;
  assign fifo_full_o  = full_c;
  assign fifo_count_o = wr_ptr_q - rd_ptr_q;

  // Storage: written at the tail, read combinationally at the head.
  ram_dual #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk_i     (fifo_clk_i),
    .we_i      (push_ok_c),
    .waddr_i   (wr_ptr_q[AW-1:0]),
    .wdata_i   (fifo_writedata_i),
    .raddr_i   (rd_ptr_q[AW-1:0]),
    .rdata_c_o (fifo_readdata_o)
  );

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Directed plus randomized bench for fifo_ctrl against a queue-based reference.
module tb_fifo_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 4;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push, pop, err_clr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          empty, full, ovf, unf;
  logic [AW:0]   count;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_q[$];
  bit            m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .fifo_clk_i       (clk),
    .fifo_rst_n_i     (rst_n),
    .fifo_push_i      (push),
    .fifo_writedata_i (wdata),
    .fifo_pop_i       (pop),
    .fifo_readdata_o  (rdata),
    .fifo_empty_o     (empty),
    .fifo_full_o      (full),
    .fifo_count_o     (count),
    .fifo_err_clr_i   (err_clr),
    .fifo_overflow_o  (ovf),
    .fifo_underflow_o (unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, ".ovf"},   32'(ovf),   32'(ERR_EN & m_ovf));
    check({tag, ".unf"},   32'(unf),   32'(ERR_EN & m_unf));
  endtask

  // One clock: drive, check head before the edge, advance model, check state after.
  task automatic cycle(input string tag, input bit p_push, input bit p_pop,
                       input logic [DW-1:0] d, input bit clr);
    bit pop_ok, push_ok;
    push = p_push; pop = p_pop; wdata = d; err_clr = clr;
    #1;
    if (model_q.size() > 0) check({tag, ".rdata"}, 32'(rdata), 32'(model_q[0]));
    @(posedge clk);
    pop_ok  = p_pop && (model_q.size() > 0);
    push_ok = p_push && ((model_q.size() < DEPTH) || pop_ok);
    if (pop_ok)  void'(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
    m_ovf = (p_push && !push_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (p_pop && !pop_ok)   ? 1'b1 : (clr ? 1'b0 : m_unf);
    #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; wdata = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    #3;
    check_state("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("post_reset");

    // Fill and drain
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 1'b1, 8'h00, 1'b0);
    check("drain_empty", 32'(empty), 32'd1);

    // Overflow while full, then clear
    for (int i = 0; i < 4; i++) cycle("fill2", 1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
    cycle("ovf", 1'b1, 1'b0, 8'hFF, 1'b0);
    cycle("ovf_clr", 1'b0, 1'b0, 8'h00, 1'b1);

    // Push and pop while full: new word lands behind the old three
    cycle("pp_full", 1'b1, 1'b1, 8'hC0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("pp_drain", 1'b0, 1'b1, 8'h00, 1'b0);

    // Push and pop while empty: only the push is taken
    cycle("pp_empty", 1'b1, 1'b1, 8'hC5, 1'b0);
    cycle("pp_empty_pop", 1'b0, 1'b1, 8'h00, 1'b1);

    // Pointer wrap
    for (int r = 0; r < 3; r++) begin
      cycle("wrap_push", 1'b1, 1'b0, 8'(8'hD0 + 2 * r), 1'b0);
      cycle("wrap_push", 1'b1, 1'b0, 8'(8'hD1 + 2 * r), 1'b0);
      cycle("wrap_pop",  1'b0, 1'b1, 8'h00, 1'b0);
      cycle("wrap_pop",  1'b0, 1'b1, 8'h00, 1'b0);
    end

    // Asynchronous reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 1'b0, 8'(8'hE0 + i), 1'b0);
    #2 rst_n = 1'b0;
    model_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    check_state("async_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("post_rst_push", 1'b1, 1'b0, 8'h5A, 1'b0);
    cycle("post_rst_pop",  1'b0, 1'b1, 8'h00, 1'b0);

    // Randomized traffic in phases biased toward filling and draining
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 120; n++) begin
        int unsigned pp;
        pp = (ph % 2 == 0) ? 75 : 30;
        cycle("rand",
              $urandom_range(0, 99) < pp,
              $urandom_range(0, 99) < (100 - pp),
              8'($urandom),
              $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_ctrl
